out_controller: RTL
===================

Name: out_controller

Overview:
- Write-back counterpart of the input-side feeder. It drains finished result rows from the MAC_SIZE×MAC_SIZE systolic array, one row per handshake.
- Each accumulator is narrowed to RES_WIDTH and packed into DATA_WIDTH words, which are written to output memory.
- Tiles are walked in the same order the input side issues them: col tile fastest, then row tile, over a BIG_MAC_SIZE matrix.
- Raises tile_done per tile and all_done after the last tile.

Parameters:
- DATA_WIDTH, 64, memory word width.
- ADDR_WIDTH, 23, memory address width.
- ACC_WIDTH, 32, signed accumulator width per PE result.
- RES_WIDTH, 8, stored result element width.
- MAC_SIZE, 32, array edge (rows per tile, elements per row).
- BIG_MAC_SIZE, 512, full matrix edge.
- OUT_BASE, 0, base address of matrix C in output memory.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse; begins a new full matrix write-back.
- res_valid, in, 1, res_row holds a valid result row.
- res_ready, out, 1, block accepts a row this cycle.
- res_row, in, MAC_SIZE*ACC_WIDTH, signed results; element 0 in the MS slice.
- mem_write_enb, out, 1, active-high memory write strobe.
- mem_address, out, ADDR_WIDTH, write address.
- data_out, out, DATA_WIDTH, write data.
- tile_done, out, 1, one-cycle pulse after the last word of a tile.
- all_done, out, 1, level; high once all tiles are written, until start or rst.
- busy, out, 1, high from start until all_done.

Behaviour:
- Derived constants:
  - PACK = DATA_WIDTH/RES_WIDTH (8).
  - WPT = MAC_SIZE/PACK (4), words per tile row.
  - DIVIDE = BIG_MAC_SIZE/MAC_SIZE (16).
  - WPB = BIG_MAC_SIZE/PACK (64), words per matrix row.
- rst (async): state=S_IDLE. row_t, col_t, r and w are 0. All outputs are 0.
- States:
  - S_IDLE: res_ready=0. On start, clear row_t/col_t/r/w and go to S_WAIT. busy is 1 from the next cycle.
  - S_WAIT: res_ready=1. On res_valid&res_ready, quantize all MAC_SIZE elements into the line buffer, set w=0, go to S_WRITE.
  - S_WRITE: res_ready=0 and mem_write_enb=1 every cycle.
    - mem_address = OUT_BASE + (row_t*MAC_SIZE + r)*WPB + col_t*WPT + w.
    - data_out = line-buffer elements w*PACK .. w*PACK+PACK-1, with element w*PACK in bits [DATA_WIDTH-1 -: RES_WIDTH] (first element at the MSB).
    - w increments each cycle.
    - At w==WPT-1 with r<MAC_SIZE-1: r++ and go to S_WAIT.
    - At w==WPT-1 with r==MAC_SIZE-1: r=0 and tile_done pulses in the next cycle.
      - col_t++; if col_t wraps from DIVIDE-1, row_t++.
      - If this was tile (DIVIDE-1, DIVIDE-1), go to S_DONE; otherwise go to S_WAIT.
  - S_DONE: all_done=1, busy=0. A start pulse restarts exactly as from S_IDLE.
- Timing:
  - The first write occurs the cycle after the accepting handshake.
  - Peak throughput is one row per WPT+1 cycles.
  - mem_write_enb, mem_address and data_out are registered and change together.
- Boundaries:
  - start while busy is ignored.
  - res_valid with res_ready=0 is not consumed; the producer holds the row.
  - Address arithmetic is done at ADDR_WIDTH, no overflow checking. The default last address is 32767.
  - rst mid-write aborts immediately; the partial tile is not reported.

Optional Feature:
- OUT_CTRL_SATURATE_EN defined: each element is clamped to the signed RES_WIDTH range [-2^(RES_WIDTH-1), 2^(RES_WIDTH-1)-1].
- Undefined: each element takes the low RES_WIDTH bits of the accumulator (wrap).

Decomposition:
- Package out_ctrl_pkg holds:
  - the state encoding S_IDLE/S_WAIT/S_WRITE/S_DONE;
  - the derived constants PACK, WPT, DIVIDE, WPB;
  - the quantize function signature.
- One sub-module, res_quant: a single-element ACC_WIDTH→RES_WIDTH narrowing (saturating or wrapping), replicated MAC_SIZE times by generate.

Test Plan:
- Reset: assert rst for 2 cycles mid-run → mem_write_enb=0, res_ready=0, busy=0, all_done=0, tile_done=0.
- Single row: start, then res_row element k = k →
  - writes to addresses 0,1,2,3;
  - data 0x0001020304050607, 0x08090A0B0C0D0E0F, 0x1011121314151617, 0x18191A1B1C1D1E1F;
  - res_ready low for exactly those 4 cycles.
- Full tile: 32 rows with res_valid held high →
  - 128 writes, row r at addresses r*64 .. r*64+3;
  - one tile_done pulse after the 128th write;
  - next tile row 0 written at address 4.
- Tile addressing: drive to tile (row_t=1, col_t=15) →
  - its row 0 starts at address 2108;
  - after 256 tiles the last address is 32767, all_done=1, busy=0.
- Quantize: elements 300 and -200 →
  - 0x7F and 0x80 with OUT_CTRL_SATURATE_EN;
  - 0x2C and 0x38 without.
- Abort/restart: rst at w=2 of a row → outputs clear in the same cycle; the next start rewrites from address 0.

Source files
------------

// File: rtl/out_ctrl_pkg.sv
// Shared types and constants for the systolic-array result write-back path.
// Build with OUT_CTRL_SATURATE_EN to clamp results instead of wrapping.
package out_ctrl_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 23;
  localparam int ACC_W  = 32;
  localparam int RES_W  = 8;
  localparam int MAC_N  = 32;
  localparam int BIG_N  = 512;

  localparam int PACK   = DATA_W / RES_W;
  localparam int WPT    = MAC_N / PACK;
  localparam int DIVIDE = BIG_N / MAC_N;
  localparam int WPB    = BIG_N / PACK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic logic [RES_W-1:0] quantize(
    input logic signed [ACC_W-1:0] acc,
    input logic                    sat
  );
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'((1 <<< (RES_W - 1)) - 1);
    lo = ~hi;
    quantize = RES_W'(acc);
    if (sat && acc > hi) quantize = RES_W'(hi);
    else if (sat && acc < lo) quantize = RES_W'(lo);
  endfunction

endpackage

// File: rtl/out_ctrl_if.sv
// Result-row handshake and output-memory write bus.
// Master is the row producer / memory side, slave is out_controller.
interface out_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 23,
  parameter int ROW_WIDTH  = 1024
);
  logic                  res_valid;
  logic                  res_ready;
  logic [ROW_WIDTH-1:0]  res_row;
  logic                  mem_write_enb;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output res_valid,
    output res_row,
    input  res_ready,
    input  mem_write_enb,
    input  mem_address,
    input  data_out
  );

  modport slave (
    input  res_valid,
    input  res_row,
    output res_ready,
    output mem_write_enb,
    output mem_address,
    output data_out
  );
endinterface

// File: rtl/out_controller_res_quant.sv
// Narrows one signed accumulator to a result element.
// OUT_CTRL_SATURATE_EN selects clamping; otherwise the low bits are kept.
module res_quant #(
  parameter int ACC_WIDTH = 32,
  parameter int RES_WIDTH = 8
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic        [RES_WIDTH-1:0] res_o
);
`ifdef OUT_CTRL_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    ACC_WIDTH'((64'sd1 <<< (RES_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;

  always_comb begin
    res_o = RES_WIDTH'(acc_i);
    if (acc_i > MAXV) res_o = RES_WIDTH'(MAXV);
    else if (acc_i < MINV) res_o = RES_WIDTH'(MINV);
  end
`else
  assign res_o = RES_WIDTH'(acc_i);
`endif
endmodule

// File: rtl/out_controller.sv
// Drains systolic-array result rows tile by tile into output memory.
// Element narrowing mode is selected by OUT_CTRL_SATURATE_EN.
module out_controller
  import out_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W,
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int ACC_WIDTH    = ACC_W,
  parameter int RES_WIDTH    = RES_W,
  parameter int MAC_SIZE     = MAC_N,
  parameter int BIG_MAC_SIZE = BIG_N,
  parameter int OUT_BASE     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  out_ctrl_if.slave  bus,
  output logic       tile_done,
  output logic       all_done,
  output logic       busy
);
  localparam int NPK  = DATA_WIDTH / RES_WIDTH;
  localparam int NWPT = MAC_SIZE / NPK;
  localparam int NDIV = BIG_MAC_SIZE / MAC_SIZE;
  localparam int NWPB = BIG_MAC_SIZE / NPK;
  localparam int LW   = MAC_SIZE * RES_WIDTH;
  localparam int TW   = (NDIV > 1) ? $clog2(NDIV) : 1;
  localparam int RW   = (MAC_SIZE > 1) ? $clog2(MAC_SIZE) : 1;
  localparam int WW   = (NWPT > 1) ? $clog2(NWPT) : 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  state_e                state_q, state_d;
  logic [TW-1:0]         row_t_q, row_t_d;
  logic [TW-1:0]         col_t_q, col_t_d;
  logic [RW-1:0]         r_q, r_d;
  logic [WW-1:0]         w_q, w_d;
  logic [LW-1:0]         line_q, line_d;
  logic [LW-1:0]         qrow;
  logic                  we_q, we_d;
  addr_t                 addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tdone_q, tdone_d;
  logic                  hs, last_w, last_r, last_c, last_tile;

  for (genvar k = 0; k < MAC_SIZE; k++) begin : g_quant
    res_quant #(
      .ACC_WIDTH (ACC_WIDTH),
      .RES_WIDTH (RES_WIDTH)
    ) u_quant (
      .acc_i (bus.res_row[(MAC_SIZE-1-k)*ACC_WIDTH +: ACC_WIDTH]),
      .res_o (qrow[(MAC_SIZE-1-k)*RES_WIDTH +: RES_WIDTH])
    );
  end

  function automatic addr_t word_addr(
    input logic [TW-1:0] rt,
    input logic [TW-1:0] ct,
    input logic [RW-1:0] rr,
    input logic [WW-1:0] ww
  );
    return addr_t'(OUT_BASE)
         + (addr_t'(rt) * addr_t'(MAC_SIZE) + addr_t'(rr)) * addr_t'(NWPB)
         + addr_t'(ct) * addr_t'(NWPT) + addr_t'(ww);
  endfunction

  // Word 0 sits in the top DATA_WIDTH bits, so element 0 lands at the MSB.
  function automatic logic [DATA_WIDTH-1:0] word_of(
    input logic [LW-1:0] ln,
    input logic [WW-1:0] ww
  );
    return ln[(NWPT - 1 - int'(ww)) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign hs        = bus.res_valid & bus.res_ready;
  assign last_w    = (w_q == WW'(NWPT - 1));
  assign last_r    = (r_q == RW'(MAC_SIZE - 1));
  assign last_c    = (col_t_q == TW'(NDIV - 1));
  assign last_tile = last_c && (row_t_q == TW'(NDIV - 1));

  assign bus.res_ready     = (state_q == S_WAIT);
  assign bus.mem_write_enb = we_q;
  assign bus.mem_address   = addr_q;
  assign bus.data_out      = data_q;
  assign tile_done         = tdone_q;
  assign all_done          = (state_q == S_DONE);
  assign busy              = (state_q == S_WAIT) || (state_q == S_WRITE);

  always_comb begin
    state_d = state_q;
    row_t_d = row_t_q;
    col_t_d = col_t_q;
    r_d     = r_q;
    w_d     = w_q;
    line_d  = line_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    tdone_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          row_t_d = '0;
          col_t_d = '0;
          r_d     = '0;
          w_d     = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (hs) begin
          line_d  = qrow;
          w_d     = '0;
          we_d    = 1'b1;
          addr_d  = word_addr(row_t_q, col_t_q, r_q, '0);
          data_d  = word_of(qrow, '0);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!last_w) begin
          w_d    = w_q + 1'b1;
          we_d   = 1'b1;
          addr_d = word_addr(row_t_q, col_t_q, r_q, w_q + 1'b1);
          data_d = word_of(line_q, w_q + 1'b1);
        end else begin
          w_d     = '0;
          state_d = S_WAIT;
          if (!last_r) begin
            r_d = r_q + 1'b1;
          end else begin
            r_d     = '0;
            tdone_d = 1'b1;
            col_t_d = last_c ? '0 : col_t_q + 1'b1;
            if (last_c) row_t_d = last_tile ? '0 : row_t_q + 1'b1;
            if (last_tile) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_t_q <= '0;
      col_t_q <= '0;
      r_q     <= '0;
      w_q     <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      tdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_t_q <= row_t_d;
      col_t_q <= col_t_d;
      r_q     <= r_d;
      w_q     <= w_d;
      line_q  <= line_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tdone_q <= tdone_d;
    end
  end

endmodule
